// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared constants, types and helpers for the player position controller
package game_pkg;

  localparam int NUM_PLAYERS = 8;
  localparam int IDX_W       = 3;
  localparam int COORD_W     = 10;

  localparam logic [7:0]  PKT_HDR        = 8'hA5;
  localparam logic [1:0]  CMD_ABS        = 2'b00;
  localparam logic [1:0]  CMD_REL        = 2'b01;
  localparam logic [15:0] TIMEOUT_CYCLES = 16'd65535;

  localparam logic [9:0] X_MIN = 10'd100;
  localparam logic [9:0] X_MAX = 10'd700;
  localparam logic [9:0] Y_MIN = 10'd60;
  localparam logic [9:0] Y_MAX = 10'd540;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CTRL,
    ST_HI,
    ST_XLO,
    ST_YLO,
    ST_CHK,
    ST_APPLY
  } parse_state_e;

  function automatic logic [9:0] default_x(input logic [2:0] idx);
    return idx[2] ? 10'd550 : 10'd250;
  endfunction

  function automatic logic [9:0] default_y(input logic [2:0] idx);
    logic [9:0] y;
    case (idx[1:0])
      2'd0:    y = 10'd150;
      2'd1:    y = 10'd250;
      2'd2:    y = 10'd350;
      default: y = 10'd450;
    endcase
    return y;
  endfunction

  // Signed 12-bit headroom covers both negative relative results and overshoot past 1023.
  function automatic logic [9:0] clamp_coord(input logic signed [11:0] v,
                                             input logic [9:0] lo,
                                             input logic [9:0] hi);
    logic [9:0] r;
    if (v < $signed({2'b00, lo}))      r = lo;
    else if (v > $signed({2'b00, hi})) r = hi;
    else                               r = v[9:0];
    return r;
  endfunction

endpackage

// File: rtl/player_pos_ctrl_if.sv
// rtl/player_pos_ctrl_if.sv - UART byte input, frame strobe and display read port bundle
interface player_pos_ctrl_if;
  import game_pkg::*;

  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               frame_start;
  logic [IDX_W-1:0]   rd_idx;
  logic [COORD_W-1:0] player_x;
  logic [COORD_W-1:0] player_y;
  logic               pkt_err;
  logic [7:0]         pkt_cnt;

  modport master (
    output rx_data, rx_valid, frame_start, rd_idx,
    input  player_x, player_y, pkt_err, pkt_cnt
  );

  modport slave (
    input  rx_data, rx_valid, frame_start, rd_idx,
    output player_x, player_y, pkt_err, pkt_cnt
  );
endinterface

// File: rtl/pkt_parser.sv
// rtl/pkt_parser.sv - 6-byte packet framing, checksum check and inter-byte timeout
module pkt_parser
  import game_pkg::*;
(
  input  logic               CLOCK_50,
  input  logic               rst_n,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               cmd_valid,
  output logic [1:0]         cmd,
  output logic [IDX_W-1:0]   idx,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               pkt_err
);

  parse_state_e state;
  logic [7:0]   ctrl_b, hi_b, xlo_b, ylo_b;
  logic [15:0]  idle_cnt;
  logic [7:0]   chk_calc;
  logic         waiting;

  assign chk_calc = ctrl_b ^ hi_b ^ xlo_b ^ ylo_b;
  assign waiting  = (state != ST_IDLE) && (state != ST_APPLY);

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ctrl_b    <= '0;
      hi_b      <= '0;
      xlo_b     <= '0;
      ylo_b     <= '0;
      idle_cnt  <= '0;
      cmd_valid <= 1'b0;
      cmd       <= '0;
      idx       <= '0;
      x         <= '0;
      y         <= '0;
      pkt_err   <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      pkt_err   <= 1'b0;
      if (!waiting || rx_valid) idle_cnt <= '0;
      else                      idle_cnt <= idle_cnt + 16'd1;

      case (state)
        ST_IDLE:  if (rx_valid && rx_data == PKT_HDR) state <= ST_CTRL;
        ST_CTRL:  if (rx_valid) begin ctrl_b <= rx_data; state <= ST_HI;  end
        ST_HI:    if (rx_valid) begin hi_b   <= rx_data; state <= ST_XLO; end
        ST_XLO:   if (rx_valid) begin xlo_b  <= rx_data; state <= ST_YLO; end
        ST_YLO:   if (rx_valid) begin ylo_b  <= rx_data; state <= ST_CHK; end
        ST_CHK: begin
          if (rx_valid) begin
            if (rx_data == chk_calc && !ctrl_b[7]) begin
              state     <= ST_APPLY;
              cmd_valid <= 1'b1;
              cmd       <= ctrl_b[7:6];
              idx       <= ctrl_b[2:0];
              x         <= {hi_b[7:6], xlo_b};
              y         <= {hi_b[5:4], ylo_b};
            end else begin
              state   <= ST_IDLE;
              pkt_err <= 1'b1;
            end
          end
        end
        ST_APPLY: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase

      // A stalled sender drops the partial packet silently.
      if (waiting && !rx_valid && idle_cnt == TIMEOUT_CYCLES - 16'd1) begin
        state <= ST_IDLE;
      end
    end
  end

endmodule

// File: rtl/player_pos_ctrl.sv
// rtl/player_pos_ctrl.sv - clamps parsed commands into a shadow table, commits to live on frame_start
module player_pos_ctrl
  import game_pkg::*;
(
  input logic               CLOCK_50,
  input logic               rst_n,
  player_pos_ctrl_if.slave  bus
);

  logic               cmd_valid;
  logic [1:0]         cmd;
  logic [IDX_W-1:0]   cmd_idx;
  logic [COORD_W-1:0] cmd_x, cmd_y;

  logic [COORD_W-1:0] shadow_x [NUM_PLAYERS];
  logic [COORD_W-1:0] shadow_y [NUM_PLAYERS];
  logic [COORD_W-1:0] live_x   [NUM_PLAYERS];
  logic [COORD_W-1:0] live_y   [NUM_PLAYERS];

  logic signed [11:0] tgt_x, tgt_y;
  logic [COORD_W-1:0] new_x, new_y;

  pkt_parser u_parser (
    .CLOCK_50  (CLOCK_50),
    .rst_n     (rst_n),
    .rx_data   (bus.rx_data),
    .rx_valid  (bus.rx_valid),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .idx       (cmd_idx),
    .x         (cmd_x),
    .y         (cmd_y),
    .pkt_err   (bus.pkt_err)
  );

  always_comb begin
    tgt_x = $signed({2'b00, cmd_x});
    tgt_y = $signed({2'b00, cmd_y});
    if (cmd == CMD_REL) begin
      tgt_x = $signed({2'b00, shadow_x[cmd_idx]}) + $signed({{2{cmd_x[9]}}, cmd_x});
      tgt_y = $signed({2'b00, shadow_y[cmd_idx]}) + $signed({{2{cmd_y[9]}}, cmd_y});
    end
    new_x = clamp_coord(tgt_x, X_MIN, X_MAX);
    new_y = clamp_coord(tgt_y, Y_MIN, Y_MAX);
  end

  // Live copies the old shadow when a write lands on the same edge as frame_start.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        shadow_x[i] <= default_x(3'(i));
        shadow_y[i] <= default_y(3'(i));
        live_x[i]   <= default_x(3'(i));
        live_y[i]   <= default_y(3'(i));
      end
      bus.pkt_cnt  <= '0;
      bus.player_x <= '0;
      bus.player_y <= '0;
    end else begin
      if (cmd_valid) begin
        shadow_x[cmd_idx] <= new_x;
        shadow_y[cmd_idx] <= new_y;
        bus.pkt_cnt       <= bus.pkt_cnt + 8'd1;
      end
      if (bus.frame_start) begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          live_x[i] <= shadow_x[i];
          live_y[i] <= shadow_y[i];
        end
      end
      bus.player_x <= live_x[bus.rd_idx];
      bus.player_y <= live_y[bus.rd_idx];
    end
  end

endmodule
